// File: rtl/wb_write_queue_if.sv
// ---------------------------------------------------------------------------
// wb_write_queue_if
//
// Bundles every signal of the write queue except clock and reset.
//   Producer side : ld_* (load responses), alu_* (ALU results)
//   Register file : RegWrite / rd / wrt_data (registered write port)
//   Forwarding    : q_rs1/q_rs2 in, fwd1_*/fwd2_* out
//   Status        : idle
//
// Modports
//   slave  - the queue itself (consumes results, drives the write port)
//   master - the surrounding pipeline / testbench
// ---------------------------------------------------------------------------
interface wb_write_queue_if #(
  parameter int XLEN = 64
);

  // Load response port (has priority over the ALU port)
  logic            ld_valid;
  logic            ld_ready;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_data;

  // ALU result port
  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;

  // Register file write port; rd[5] is always 0
  logic            RegWrite;
  logic [5:0]      rd;
  logic [XLEN-1:0] wrt_data;

  // Operand forwarding
  logic [4:0]      q_rs1;
  logic [4:0]      q_rs2;
  logic            fwd1_hit;
  logic            fwd2_hit;
  logic [XLEN-1:0] fwd1_data;
  logic [XLEN-1:0] fwd2_data;

  logic            idle;

  modport slave (
    input  ld_valid, ld_rd, ld_data,
    input  alu_valid, alu_rd, alu_data,
    input  q_rs1, q_rs2,
    output ld_ready, alu_ready,
    output RegWrite, rd, wrt_data,
    output fwd1_hit, fwd2_hit, fwd1_data, fwd2_data,
    output idle
  );

  modport master (
    output ld_valid, ld_rd, ld_data,
    output alu_valid, alu_rd, alu_data,
    output q_rs1, q_rs2,
    input  ld_ready, alu_ready,
    input  RegWrite, rd, wrt_data,
    input  fwd1_hit, fwd2_hit, fwd1_data, fwd2_data,
    input  idle
  );

endinterface

// File: rtl/wb_write_queue.sv
// ---------------------------------------------------------------------------
// wb_write_queue
//
// Collects completed results from the load-response and ALU paths into an
// in-order circular queue and drains one register-file write per cycle onto
// a registered write port. Pending (queued or just-issued) values are
// forwarded to two operand readers, youngest value first.
//
// Ports
//   clk   - single clock, all state on the rising edge
//   reset - asynchronous, active-high; discards all pending results
//   bus   - wb_write_queue_if.slave (load/ALU handshakes, register file
//           write port, forwarding lookups, idle)
//
// Parameters
//   DEPTH - queue entries, power of two, >= 2
//   XLEN  - data width
// ---------------------------------------------------------------------------
module wb_write_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64
) (
  input  logic             clk,
  input  logic             reset,
  wb_write_queue_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  // Occupancy needs one more bit than the pointers to represent "full".
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [4:0]      rd_mem   [DEPTH];
  logic [XLEN-1:0] data_mem [DEPTH];

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW:0]     count_q,  count_d;

  logic            regwrite_q, regwrite_d;
  logic [5:0]      rd_q,       rd_d;
  logic [XLEN-1:0] wrt_data_q, wrt_data_d;

  // -------------------------------------------------------------------------
  // Handshake
  // -------------------------------------------------------------------------
  logic          ld_ready;
  logic          alu_ready;
  logic          ld_acc;
  logic          alu_acc;
  logic          ld_push;
  logic          alu_push;
  logic          pop;
  logic [PW-1:0] alu_slot;

  // Readiness never credits a same-cycle pop, and the ALU port reserves a
  // slot for a load offered in the same cycle, so two accepts can never
  // overflow the queue.
  assign ld_ready  = count_q < FULL;
  assign alu_ready = (count_q + (PW+1)'(bus.ld_valid)) < FULL;

  assign ld_acc    = bus.ld_valid  & ld_ready;
  assign alu_acc   = bus.alu_valid & alu_ready;

  // Results for x0 complete their handshake but never occupy a slot.
  assign ld_push   = ld_acc  & (bus.ld_rd  != 5'd0);
  assign alu_push  = alu_acc & (bus.alu_rd != 5'd0);

  assign pop       = count_q != '0;

  // When both ports push, the load takes the tail slot and the ALU result
  // the slot behind it, which fixes drain order as load-then-ALU.
  assign alu_slot  = wr_ptr_q + PW'(ld_push);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d   = wr_ptr_q + PW'(ld_push) + PW'(alu_push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    count_d    = count_q + (PW+1)'(ld_push) + (PW+1)'(alu_push)
                 - (PW+1)'(pop);

    // Address and data hold their last value when nothing drains.
    regwrite_d = pop;
    rd_d       = rd_q;
    wrt_data_d = wrt_data_q;
    if (pop) begin
      rd_d       = {1'b0, rd_mem[rd_ptr_q]};
      wrt_data_d = data_mem[rd_ptr_q];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      wrt_data_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      wrt_data_q <= wrt_data_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; an entry is only
  // meaningful while count_q covers it, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (ld_push) begin
      rd_mem[wr_ptr_q]   <= bus.ld_rd;
      data_mem[wr_ptr_q] <= bus.ld_data;
    end
    if (alu_push) begin
      rd_mem[alu_slot]   <= bus.alu_rd;
      data_mem[alu_slot] <= bus.alu_data;
    end
  end

  // -------------------------------------------------------------------------
  // Forwarding
  //
  // Candidates are scanned oldest to youngest: the output register first
  // (it is older than anything still queued), then queue entries from head
  // to tail. Each later match overwrites an earlier one, so the youngest
  // pending value wins.
  // -------------------------------------------------------------------------
  logic            fwd1_hit;
  logic            fwd2_hit;
  logic [XLEN-1:0] fwd1_data;
  logic [XLEN-1:0] fwd2_data;
  logic [PW-1:0]   fwd_idx;
  logic            fwd_live;

  // NOTE: every combinational output gets a default before any condition,
  // otherwise an unassigned path would infer a latch.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd2_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_data = '0;
    fwd_idx   = '0;
    fwd_live  = 1'b0;

    if (regwrite_q) begin
      if (rd_q[4:0] == bus.q_rs1) begin
        fwd1_hit  = 1'b1;
        fwd1_data = wrt_data_q;
      end
      if (rd_q[4:0] == bus.q_rs2) begin
        fwd2_hit  = 1'b1;
        fwd2_data = wrt_data_q;
      end
    end

    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx  = rd_ptr_q + PW'(i);
      fwd_live = (PW+1)'(i) < count_q;
      if (fwd_live && rd_mem[fwd_idx] == bus.q_rs1) begin
        fwd1_hit  = 1'b1;
        fwd1_data = data_mem[fwd_idx];
      end
      if (fwd_live && rd_mem[fwd_idx] == bus.q_rs2) begin
        fwd2_hit  = 1'b1;
        fwd2_data = data_mem[fwd_idx];
      end
    end

    // x0 is hard-wired to zero; no pending entry ever targets it, but the
    // output register may still hold a stale address, so mask explicitly.
    if (bus.q_rs1 == 5'd0) begin
      fwd1_hit  = 1'b0;
      fwd1_data = '0;
    end
    if (bus.q_rs2 == 5'd0) begin
      fwd2_hit  = 1'b0;
      fwd2_data = '0;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.ld_ready  = ld_ready;
  assign bus.alu_ready = alu_ready;
  assign bus.RegWrite  = regwrite_q;
  assign bus.rd        = rd_q;
  assign bus.wrt_data  = wrt_data_q;
  assign bus.fwd1_hit  = fwd1_hit;
  assign bus.fwd2_hit  = fwd2_hit;
  assign bus.fwd1_data = fwd1_data;
  assign bus.fwd2_data = fwd2_data;
  assign bus.idle      = (count_q == '0) & ~regwrite_q;

endmodule

// File: tb/tb_wb_write_queue.sv
// ---------------------------------------------------------------------------
// tb_wb_write_queue
//
// Directed scenarios followed by a randomized phase. A queue-based reference
// model tracks pending results and the register-file output stage; every
// cycle the DUT's readys, write port, forwarding outputs, idle and occupancy
// are compared against it.
// ---------------------------------------------------------------------------
module tb_wb_write_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 64;

  logic clk;
  logic reset;

  wb_write_queue_if #(.XLEN(XLEN)) bus ();

  wb_write_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t            mq[$];
  logic            m_we;
  logic [5:0]      m_rd;
  logic [XLEN-1:0] m_data;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_we   = 1'b0;
    m_rd   = '0;
    m_data = '0;
  endtask

  function automatic logic exp_ld_ready();
    return mq.size() < DEPTH;
  endfunction

  function automatic logic exp_alu_ready(input logic ld_v);
    return (mq.size() + int'(ld_v)) < DEPTH;
  endfunction

  // Youngest pending value: newest queue entry first, then the write port.
  task automatic exp_fwd(input logic [4:0] rs, output logic hit,
                         output logic [XLEN-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (rs != 5'd0) begin
      for (int i = mq.size() - 1; i >= 0 && !hit; i--) begin
        if (mq[i].rd == rs) begin
          hit = 1'b1;
          d   = mq[i].data;
        end
      end
      if (!hit && m_we && m_rd[4:0] == rs) begin
        hit = 1'b1;
        d   = m_data;
      end
    end
  endtask

  task automatic clear_inputs();
    bus.ld_valid  = 1'b0;
    bus.ld_rd     = '0;
    bus.ld_data   = '0;
    bus.alu_valid = 1'b0;
    bus.alu_rd    = '0;
    bus.alu_data  = '0;
  endtask

  // One clock cycle: inputs are already driven (just after a falling edge).
  // Compare all outputs against the model, then advance the model at the
  // rising edge and return at the next falling edge.
  task automatic step(output logic ld_acc, output logic alu_acc);
    logic            h1, h2;
    logic [XLEN-1:0] d1, d2;
    logic            ldr, alr;
    ent_t            e;
    #1;
    ldr = exp_ld_ready();
    alr = exp_alu_ready(bus.ld_valid);
    exp_fwd(bus.q_rs1, h1, d1);
    exp_fwd(bus.q_rs2, h2, d2);
    check("ld_ready",  bus.ld_ready,  ldr);
    check("alu_ready", bus.alu_ready, alr);
    check("RegWrite",  bus.RegWrite,  m_we);
    check("rd",        bus.rd,        m_rd);
    check("wrt_data",  bus.wrt_data,  m_data);
    check("fwd1_hit",  bus.fwd1_hit,  h1);
    check("fwd1_data", bus.fwd1_data, d1);
    check("fwd2_hit",  bus.fwd2_hit,  h2);
    check("fwd2_data", bus.fwd2_data, d2);
    check("idle",      bus.idle,      mq.size() == 0 && !m_we);
    check("count",     64'(dut.count_q), 64'(mq.size()));

    @(posedge clk);
    ld_acc  = bus.ld_valid  & ldr;
    alu_acc = bus.alu_valid & alr;
    if (mq.size() > 0) begin
      e      = mq.pop_front();
      m_we   = 1'b1;
      m_rd   = {1'b0, e.rd};
      m_data = e.data;
    end else begin
      m_we   = 1'b0;
    end
    if (ld_acc && bus.ld_rd != 5'd0)
      mq.push_back('{rd: bus.ld_rd, data: bus.ld_data});
    if (alu_acc && bus.alu_rd != 5'd0)
      mq.push_back('{rd: bus.alu_rd, data: bus.alu_data});
    @(negedge clk);
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    logic la, aa;
    int   alu_idx;

    reset     = 1'b1;
    bus.q_rs1 = '0;
    bus.q_rs2 = '0;
    clear_inputs();
    model_reset();

    // Reset state
    #12;
    check("rst_RegWrite",  bus.RegWrite,  1'b0);
    check("rst_rd",        bus.rd,        6'd0);
    check("rst_wrt_data",  bus.wrt_data,  64'd0);
    check("rst_idle",      bus.idle,      1'b1);
    check("rst_ld_ready",  bus.ld_ready,  1'b1);
    check("rst_alu_ready", bus.alu_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;

    // Single ALU result rd=5 / 0x1234
    bus.q_rs1     = 5'd5;
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd5;
    bus.alu_data  = 64'h1234;
    step(la, aa);                                   // edge 1: accept
    clear_inputs();
    check("t1_fwd_c1", bus.fwd1_hit, 1'b1);
    step(la, aa);                                   // edge 2: pop
    check("t1_we",     bus.RegWrite, 1'b1);
    check("t1_rd",     bus.rd,       6'd5);
    check("t1_data",   bus.wrt_data, 64'h1234);
    check("t1_fwd_c2", bus.fwd1_hit, 1'b1);
    step(la, aa);                                   // edge 3
    check("t1_we_low", bus.RegWrite, 1'b0);
    step(la, aa);

    // Simultaneous load and ALU into an empty queue
    bus.ld_valid  = 1'b1;
    bus.ld_rd     = 5'd3;
    bus.ld_data   = 64'hAA;
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd4;
    bus.alu_data  = 64'hBB;
    step(la, aa);
    clear_inputs();
    check("t2_count2", 64'(dut.count_q), 64'd2);
    step(la, aa);
    check("t2_first_rd",  bus.rd, 6'd3);
    step(la, aa);
    check("t2_second_rd", bus.rd, 6'd4);
    for (int c = 0; c < 3; c++) step(la, aa);

    // Sustained pressure: ALU rd=1..8, loads for 4 cycles
    alu_idx = 0;
    for (int c = 0; c < 40 && alu_idx < 8; c++) begin
      bus.ld_valid  = (c < 4);
      bus.ld_rd     = 5'(20 + c);
      bus.ld_data   = 64'h1000 + 64'(c);
      bus.alu_valid = 1'b1;
      bus.alu_rd    = 5'(alu_idx + 1);
      bus.alu_data  = 64'h2000 + 64'(alu_idx);
      step(la, aa);
      if (aa) alu_idx++;
    end
    check("t3_all_alu_accepted", 64'(alu_idx), 64'd8);
    clear_inputs();
    for (int c = 0; c < 12; c++) step(la, aa);

    // Two pending writes to x7; the younger one must always win
    bus.q_rs2     = 5'd7;
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd7;
    bus.alu_data  = 64'h10;
    step(la, aa);
    bus.alu_data  = 64'h20;
    step(la, aa);
    clear_inputs();
    check("t4_young", bus.fwd2_data, 64'h20);
    for (int c = 0; c < 4; c++) step(la, aa);
    check("t4_hit_gone", bus.fwd2_hit, 1'b0);

    // Destination x0 is accepted but discarded
    bus.q_rs1     = 5'd0;
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd0;
    bus.alu_data  = 64'hFF;
    step(la, aa);
    clear_inputs();
    check("t5_accepted", aa, 1'b1);
    check("t5_count",    64'(dut.count_q), 64'd0);
    check("t5_fwd1_x0",  bus.fwd1_hit, 1'b0);
    step(la, aa);
    check("t5_no_write", bus.RegWrite, 1'b0);

    // Asynchronous reset with 3 entries queued and a write on the port
    bus.q_rs1     = 5'd11;
    bus.ld_valid  = 1'b1;
    bus.ld_rd     = 5'd11;
    bus.ld_data   = 64'hA1;
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd12;
    bus.alu_data  = 64'hA2;
    step(la, aa);
    bus.ld_rd     = 5'd13;
    bus.ld_data   = 64'hA3;
    bus.alu_rd    = 5'd14;
    bus.alu_data  = 64'hA4;
    step(la, aa);
    clear_inputs();
    check("t6_pre_we",    bus.RegWrite, 1'b1);
    check("t6_pre_count", 64'(dut.count_q), 64'd3);
    #2 reset = 1'b1;
    #1;
    check("t6_async_we",   bus.RegWrite, 1'b0);
    check("t6_async_rd",   bus.rd,       6'd0);
    check("t6_async_data", bus.wrt_data, 64'd0);
    check("t6_async_idle", bus.idle,     1'b1);
    check("t6_async_fwd",  bus.fwd1_hit, 1'b0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) step(la, aa);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      bus.ld_valid  = ($urandom_range(0, 2) != 0);
      bus.ld_rd     = 5'($urandom_range(0, 7));
      bus.ld_data   = {$urandom, $urandom};
      bus.alu_valid = ($urandom_range(0, 2) != 0);
      bus.alu_rd    = 5'($urandom_range(0, 7));
      bus.alu_data  = {$urandom, $urandom};
      bus.q_rs1     = 5'($urandom_range(0, 7));
      bus.q_rs2     = 5'($urandom_range(0, 7));
      step(la, aa);
    end
    clear_inputs();
    for (int c = 0; c < 8; c++) step(la, aa);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
